// File: rtl/shift_unit_seq_if.sv
// Request/response bundle for the multicycle shift/rotate unit.
// The sequencer drives the master side; shift_unit_seq sits on the slave side.
interface shift_unit_seq_if #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 4,
  parameter int SEL_W  = 2
);
  localparam int SHAMT_W = $clog2(DATA_W);

  logic                       start;
  logic [2:0]                 op;
  logic [SEL_W-1:0]           shamt_sel;
  logic [N_SRC*SHAMT_W-1:0]   shamt_src;
  logic [DATA_W-1:0]          data_in;
  logic                       busy;
  logic                       done;
  logic [DATA_W-1:0]          data_out;

  modport master (
    output start, op, shamt_sel, shamt_src, data_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, shamt_sel, shamt_src, data_in,
    output busy, done, data_out
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multicycle shift/rotate unit: picks a shift amount from N_SRC sources,
// then shifts the latched operand by up to STEP bits per clock.
// IDLE -> SHIFT (busy) -> DONE (one-cycle done pulse) -> IDLE, with
// back-to-back starts accepted in DONE.
module shift_unit_seq #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 4,
  parameter int SEL_W  = 2,
  parameter int STEP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  shift_unit_seq_if.slave  bus
);
  localparam int SHAMT_W = $clog2(DATA_W);
  // The remaining count never exceeds DATA_W-1, so a larger STEP behaves
  // exactly like DATA_W-1 and the clamped value fits in SHAMT_W bits.
  localparam int STEP_C = (STEP >= DATA_W) ? DATA_W - 1 : STEP;
  localparam logic [SHAMT_W-1:0] STEP_S = SHAMT_W'(STEP_C);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic [SHAMT_W-1:0]  rem;
  logic [SHAMT_W-1:0]  amt;
  logic [SHAMT_W-1:0]  step;
  logic [SHAMT_W:0]    back;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   shifted;
  logic [SEL_W-1:0]    sel;
  logic                accept;
  logic                pass;

  assign sel    = bus.shamt_sel;
  assign accept = bus.start && (state != SHIFT);
  // Zero amount and op codes 5-7 complete without entering SHIFT.
  assign pass   = (amt == '0) || (bus.op > 3'd4);

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.data_out = result_q;

  // Amount mux; selectors past the last source yield zero.
  always_comb begin
    amt = '0;
    for (int i = 0; i < N_SRC; i++)
      if (int'(sel) == i) amt = bus.shamt_src[i*SHAMT_W +: SHAMT_W];
  end

  // One shift step of min(STEP, rem) bits on the working register.
  always_comb begin
    step = (rem > STEP_S) ? STEP_S : rem;
    back = (SHAMT_W+1)'(DATA_W) - {1'b0, step};
    case (op_q)
      3'd0:    shifted = result_q << step;
      3'd1:    shifted = result_q >> step;
      3'd2:    shifted = $signed(result_q) >>> step;
      3'd3:    shifted = (result_q >> step) | (result_q << back);
      3'd4:    shifted = (result_q << step) | (result_q >> back);
      default: shifted = result_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; SHIFT ends on the step that drains the count.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? (pass ? DONE : SHIFT) : IDLE;
      SHIFT:      if (rem == step) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Operand/op/count capture on start, stepwise update while shifting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      op_q     <= '0;
      rem      <= '0;
    end else if (accept) begin
      result_q <= bus.data_in;
      op_q     <= bus.op;
      rem      <= pass ? '0 : amt;
    end else if (state == SHIFT) begin
      result_q <= shifted;
      rem      <= rem - step;
    end
  end
endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: one STEP=1 and one STEP=4 instance driven with
// identical stimulus, each checked cycle by cycle against a whole-amount
// arithmetic reference.
module tb_shift_unit_seq;
  localparam int DATA_W  = 32;
  localparam int N_SRC   = 4;
  localparam int SEL_W   = 2;
  localparam int SHAMT_W = 5;
  localparam int SRC_W   = N_SRC * SHAMT_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  shift_unit_seq_if #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) bus1 ();
  shift_unit_seq_if #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) bus4 ();

  shift_unit_seq #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  shift_unit_seq #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SRC_W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // Whole-amount reference result.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input int k, input logic [31:0] d);
    logic [63:0] dd;
    logic [63:0] t;
    dd = {d, d};
    case (op)
      3'd0: return d << k;
      3'd1: return d >> k;
      3'd2: return $signed(d) >>> k;
      3'd3: begin t = dd >> k; return t[31:0];  end
      3'd4: begin t = dd << k; return t[63:32]; end
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input int k, input int s);
    if (k == 0 || op > 3'd4) return 0;
    return (k + s - 1) / s;
  endfunction

  task automatic drive(input logic st, input logic [2:0] op, input logic [SEL_W-1:0] sel,
                       input logic [SRC_W-1:0] src, input logic [31:0] d);
    bus1.start = st; bus1.op = op; bus1.shamt_sel = sel; bus1.shamt_src = src; bus1.data_in = d;
    bus4.start = st; bus4.op = op; bus4.shamt_sel = sel; bus4.shamt_src = src; bus4.data_in = d;
  endtask

  task automatic set_start(input logic st);
    bus1.start = st;
    bus4.start = st;
  endtask

  task automatic chk_cyc(input string tag, input int c, input int l, input logic [31:0] exp,
                         input logic b, input logic dn, input logic [31:0] q);
    chk($sformatf("%s c%0d busy", tag, c), 32'(b),  32'(c <= l));
    chk($sformatf("%s c%0d done", tag, c), 32'(dn), 32'(c == l + 1));
    if (c > l) chk($sformatf("%s c%0d data", tag, c), q, exp);
  endtask

  // Called just after a falling edge. Returns at the falling edge of the
  // slower instance's done cycle, so a following call chains back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [SEL_W-1:0] sel,
                        input logic [SRC_W-1:0] src, input logic [31:0] d,
                        input bit poke, input bit hold);
    int k, l1, l4, last;
    logic [31:0] exp;
    k = (int'(sel) < N_SRC) ? int'(src[int'(sel)*SHAMT_W +: SHAMT_W]) : 0;
    exp = ref_res(op, k, d);
    l1 = ref_lat(op, k, 1);
    l4 = ref_lat(op, k, 4);
    last = ((l1 > l4) ? l1 : l4) + 1;
    drive(1'b1, op, sel, src, d);
    @(posedge clk); #1;
    if (!hold) drive(1'b0, 3'($urandom), SEL_W'($urandom), SRC_W'($urandom), $urandom);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      chk_cyc({tag, "/s1"}, c, l1, exp, bus1.busy, bus1.done, bus1.data_out);
      chk_cyc({tag, "/s4"}, c, l4, exp, bus4.busy, bus4.done, bus4.data_out);
      if (poke && !hold && c == 1 && l4 > 0) begin
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
      end
    end
  endtask

  initial begin
    drive(1'b0, 3'd0, '0, '0, 32'h0);
    #2;
    chk("rst busy1", 32'(bus1.busy), 32'd0);
    chk("rst done1", 32'(bus1.done), 32'd0);
    chk("rst data1", bus1.data_out, 32'd0);
    chk("rst busy4", 32'(bus4.busy), 32'd0);
    chk("rst done4", 32'(bus4.done), 32'd0);
    chk("rst data4", bus4.data_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Long SLL through source 2.
    run_op("sll31", 3'd0, 2'd2, pack(3, 9, 31, 1), 32'h0000_0001, 1'b0, 1'b0);
    // Arithmetic vs logical right shift of a negative operand.
    run_op("sra4", 3'd2, 2'd0, pack(4, 0, 0, 0), 32'h8000_00F0, 1'b0, 1'b0);
    run_op("srl4", 3'd1, 2'd0, pack(4, 0, 0, 0), 32'h8000_00F0, 1'b0, 1'b0);
    // Rotates, and each selector reaching its own source.
    run_op("ror8", 3'd3, 2'd1, pack(2, 8, 17, 25), 32'h1234_5678, 1'b0, 1'b0);
    run_op("rol8", 3'd4, 2'd3, pack(2, 17, 25, 8), 32'h1234_5678, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++)
      run_op($sformatf("rolsel%0d", s), 3'd4, SEL_W'(s), pack(3, 7, 12, 29), 32'h1234_5678, 1'b0, 1'b0);
    // Zero amount, passthrough op, start pulsed while busy.
    run_op("amt0", 3'd0, 2'd1, pack(5, 0, 5, 5), 32'hCAFE_F00D, 1'b0, 1'b0);
    run_op("op6", 3'd6, 2'd0, pack(9, 9, 9, 9), 32'h0BAD_BEEF, 1'b0, 1'b0);
    run_op("poke", 3'd1, 2'd0, pack(10, 1, 1, 1), 32'hF0F0_1234, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    drive(1'b1, 3'd0, 2'd0, pack(20, 0, 0, 0), 32'hDEAD_BEEF);
    @(posedge clk); #1;
    set_start(1'b0);
    repeat (3) @(negedge clk);
    chk("pre-rst busy1", 32'(bus1.busy), 32'd1);
    chk("pre-rst busy4", 32'(bus4.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid-rst busy1", 32'(bus1.busy), 32'd0);
    chk("mid-rst done1", 32'(bus1.done), 32'd0);
    chk("mid-rst data1", bus1.data_out, 32'd0);
    chk("mid-rst busy4", 32'(bus4.busy), 32'd0);
    chk("mid-rst done4", 32'(bus4.done), 32'd0);
    chk("mid-rst data4", bus4.data_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("post-rst", 3'd2, 2'd3, pack(0, 0, 0, 13), 32'h9234_5678, 1'b0, 1'b0);

    // Start held high through DONE: second op accepted in the DONE cycle.
    run_op("hold-a", 3'd0, 2'd0, pack(1, 0, 0, 0), 32'h4000_0003, 1'b0, 1'b1);
    run_op("hold-b", 3'd3, 2'd1, pack(0, 13, 0, 0), 32'hA5A5_0F0F, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 40; i++)
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), SEL_W'($urandom),
             SRC_W'($urandom), $urandom, 1'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
